r5_input_collector: RTL and testbench



---
 rtl/r5_input_collector.sv | 90 +++++++++
 tb/tb_r5_input_collector.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/r5_input_collector.sv
// Serial-to-parallel ping-pong collector: packs 5 consecutive complex samples
// into a frame and presents it as 5 parallel operands to the radix-5 butterfly.
module r5_input_collector #(
   parameter int DW  = 32,
   parameter int FCW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [DW-1:0]   in_re,
   input  logic [DW-1:0]   in_img,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [5*DW-1:0] out_re,
   output logic [5*DW-1:0] out_img,
   output logic [FCW-1:0]  frame_cnt
);

   logic [DW-1:0] bank_re [2][5];
   logic [DW-1:0] bank_im [2][5];
   logic [1:0]    full;
   logic          wr_bank;
   logic          rd_bank;
   logic [2:0]    wr_cnt;

   logic wr_fire;
   logic rd_fire;
   logic wr_last;

   // Handshake readiness depends only on registered state, so there is no
   // combinational path from in_valid/out_ready to the ready/valid outputs.
   assign in_ready  = ~full[wr_bank];
   assign out_valid = full[rd_bank];

   assign wr_fire = in_valid & in_ready;
   assign rd_fire = out_valid & out_ready;
   assign wr_last = (wr_cnt == 3'd4);

   always_comb begin
      out_re  = '0;
      out_img = '0;
      for (int k = 0; k < 5; k++) begin
         out_re[DW*k +: DW]  = bank_re[rd_bank][k];
         out_img[DW*k +: DW] = bank_im[rd_bank][k];
      end
   end

   // A write needs ~full and a read needs full, so the two never hit the same
   // bank in one cycle and both full-bit updates can be applied independently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full      <= 2'b00;
         wr_bank   <= 1'b0;
         rd_bank   <= 1'b0;
         wr_cnt    <= 3'd0;
         frame_cnt <= '0;
      end else begin
         if (wr_fire) begin
            if (wr_last) begin
               full[wr_bank] <= 1'b1;
               wr_cnt        <= 3'd0;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 3'd1;
            end
         end
         if (rd_fire) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
            frame_cnt     <= frame_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 5; k++) begin
               bank_re[b][k] <= '0;
               bank_im[b][k] <= '0;
            end
         end
      end else if (wr_fire) begin
         bank_re[wr_bank][wr_cnt] <= in_re;
         bank_im[wr_bank][wr_cnt] <= in_img;
      end
   end

endmodule

// File: tb/tb_r5_input_collector.sv
// Bench for r5_input_collector: directed scenarios plus random traffic, checked
// against a queue-based frame model; a second FCW=2 instance covers counter wrap.
module tb_r5_input_collector;

   localparam int DW = 32;

   logic            clk;
   logic            rst_n;
   logic            in_valid;
   logic [DW-1:0]   in_re;
   logic [DW-1:0]   in_img;
   logic            out_ready;

   logic            in_ready,  in_ready2;
   logic            out_valid, out_valid2;
   logic [5*DW-1:0] out_re,    out_re2;
   logic [5*DW-1:0] out_img,   out_img2;
   logic [15:0]     frame_cnt;
   logic [1:0]      frame_cnt2;

   r5_input_collector #(.DW(DW), .FCW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_img(in_img),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_re(out_re), .out_img(out_img), .frame_cnt(frame_cnt)
   );

   r5_input_collector #(.DW(DW), .FCW(2)) dut_w (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready2), .in_re(in_re), .in_img(in_img),
      .out_valid(out_valid2), .out_ready(out_ready),
      .out_re(out_re2), .out_img(out_img2), .frame_cnt(frame_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: partial frame being gathered, queue of complete frames
   // awaiting delivery (oldest first), and the count of frames delivered.
   logic [DW-1:0]   part_re[$];
   logic [DW-1:0]   part_im[$];
   logic [5*DW-1:0] fr_re_q[$];
   logic [5*DW-1:0] fr_im_q[$];
   int unsigned     delivered;
   bit              last_acc;

   task automatic chk(input string tag, input logic [5*DW-1:0] got, input logic [5*DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      part_re.delete();
      part_im.delete();
      fr_re_q.delete();
      fr_im_q.delete();
      delivered = 0;
   endtask

   task automatic check_outputs();
      bit exp_rdy;
      bit exp_vld;
      exp_rdy = (fr_re_q.size() < 2);
      exp_vld = (fr_re_q.size() > 0);
      chk("in_ready",   {159'd0, in_ready},   {159'd0, exp_rdy});
      chk("out_valid",  {159'd0, out_valid},  {159'd0, exp_vld});
      chk("frame_cnt",  {144'd0, frame_cnt},  160'(delivered % 65536));
      chk("frame_cnt2", {158'd0, frame_cnt2}, 160'(delivered % 4));
      if (exp_vld) begin
         chk("out_re",  out_re,  fr_re_q[0]);
         chk("out_img", out_img, fr_im_q[0]);
      end
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_in_ready"},  {159'd0, in_ready},  160'd1);
      chk({tag, "_out_valid"}, {159'd0, out_valid}, 160'd0);
      chk({tag, "_out_re"},    out_re,              160'd0);
      chk({tag, "_out_img"},   out_img,             160'd0);
      chk({tag, "_frame_cnt"}, {144'd0, frame_cnt}, 160'd0);
   endtask

   // Called at a positive edge with the inputs that were presented.
   task automatic model_edge();
      bit acc;
      bit rd;
      logic [5*DW-1:0] fr, fi;
      acc = in_valid && (fr_re_q.size() < 2);
      rd  = out_ready && (fr_re_q.size() > 0);
      if (rd) begin
         void'(fr_re_q.pop_front());
         void'(fr_im_q.pop_front());
         delivered++;
      end
      if (acc) begin
         part_re.push_back(in_re);
         part_im.push_back(in_img);
         if (part_re.size() == 5) begin
            fr = '0;
            fi = '0;
            for (int k = 0; k < 5; k++) begin
               fr[DW*k +: DW] = part_re[k];
               fi[DW*k +: DW] = part_im[k];
            end
            fr_re_q.push_back(fr);
            fr_im_q.push_back(fi);
            part_re.delete();
            part_im.delete();
         end
      end
      last_acc = acc;
   endtask

   // One clock: check settled outputs, drive inputs at the falling edge,
   // advance the model at the rising edge, return to the falling edge.
   task automatic cycle(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input logic ordy);
      check_outputs();
      in_valid  = v;
      in_re     = re;
      in_img    = im;
      out_ready = ordy;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      int idx;
      bit gap_pat [9];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_re     = '0;
      in_img    = '0;
      out_ready = 1'b0;
      last_acc  = 1'b0;
      model_reset();

      // Reset held for 3 cycles with random inputs, released mid-cycle.
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'($urandom);
         in_re     = $urandom;
         in_img    = $urandom;
         out_ready = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         check_reset_state("rst");
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b1;
      #1;
      check_reset_state("rst_rel");
      @(negedge clk);

      // Streaming: 10 samples back to back, downstream always ready.
      for (int k = 0; k < 10; k++)
         cycle(1'b1, 32'h3F80_0000 + k, 32'hBF80_0000 + k, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1);
      chk("stream_frames", {144'd0, frame_cnt}, 160'd2);

      // Backpressure: upstream offers 12, holds unaccepted data, downstream stalled.
      idx = 0;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 32'h1000 + idx, 32'h2000 + idx, 1'b0);
         if (last_acc) idx++;
      end
      chk("bp_accepted", 160'(idx), 160'd10);
      for (int i = 0; i < 2; i++) cycle(1'b1, 32'h1000 + idx, 32'h2000 + idx, 1'b0);
      cycle(1'b1, 32'h1000 + idx, 32'h2000 + idx, 1'b1);
      while (idx < 15) begin
         cycle(1'b1, 32'h1000 + idx, 32'h2000 + idx, 1'b0);
         if (last_acc) idx++;
         if (idx > 15) break;
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);

      // Gapped input with downstream ready.
      gap_pat = '{1, 0, 0, 1, 1, 0, 1, 0, 1};
      for (int i = 0; i < 9; i++)
         cycle(gap_pat[i], 32'h5000 + i, 32'h6000 + i, 1'b1);
      for (int i = 0; i < 2; i++) cycle(1'b0, '0, '0, 1'b1);

      // Reset mid-frame: 3 samples discarded, then a fresh frame A..E.
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'hDEAD_0000 + i, 32'hBEEF_0000 + i, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_state("mid_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA0 + i, 32'hE0 + i, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      chk("mid_rst_frames", {144'd0, frame_cnt}, 160'd1);

      // Random traffic; also walks the FCW=2 instance through several wraps.
      for (int i = 0; i < 600; i++)
         cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
               1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b1);
      check_outputs();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
